prescaled_multi_counter: RTL and testbench
==========================================

Name: prescaled_multi_counter

Overview:
- Parametrised bank of CHANNELS independent event counters, each WIDTH bits wide.
- Each channel has its own runtime-programmable prescaler.
- One channel is selected per cycle by Slt; while En is high, that channel's prescaler advances, and its count increments once every DIV enabled cycles.
- Used as a general-purpose event/cycle statistics block, with per-channel wrap flags for software overflow tracking.

Parameters:
- WIDTH, 64: bit width of each channel count.
- CHANNELS, 4: number of channels, 1..16.
- DIV_W, 8: bit width of each channel's divisor and prescaler.
- DEFAULT_DIV, 4: reset value of every channel divisor, 1..2^DIV_W-1.
- SEL_W, max(1, clog2(CHANNELS)): derived select width; never overridden.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- En  input  1  count enable for the channel selected by Slt.
- Slt  input  SEL_W  selected channel for En/Clr.
- Clr  input  1  synchronous clear of the selected channel's count and prescaler.
- Cfg_we  input  1  divisor write strobe.
- Cfg_sel  input  SEL_W  channel targeted by a divisor write.
- Cfg_div  input  DIV_W  new divisor value; 0 is treated as 1.
- Count  output  CHANNELS*WIDTH  packed registered counts; channel c occupies bits [c*WIDTH +: WIDTH].
- Wrap  output  CHANNELS  registered one-cycle pulse per channel on count wrap.

Behaviour:
- Reset: on a rising edge with Reset_n=0:
  - every count = 0, every prescaler = 0, every divisor = DEFAULT_DIV, Wrap = 0.
  - Reset overrides all other inputs.
  - A reset mid-prescale discards the partial prescale.
- Per-channel state: count[c] (WIDTH bits), pre[c] (DIV_W bits), div[c] (DIV_W bits). Effective divisor deff = (div==0) ? 1 : div.
- Count step, when Reset_n=1, En=1, Clr=0 and Slt<CHANNELS, for channel s=Slt:
  - if pre[s] == deff-1: pre[s] <= 0 and count[s] <= count[s]+1 (mod 2^WIDTH).
  - otherwise: pre[s] <= pre[s]+1.
  - Unselected channels hold state.
- En=0: all prescalers and counts hold. Gaps in En do not reset a partial prescale.
- Out-of-range select: Slt >= CHANNELS means En and Clr have no effect. Likewise Cfg_sel >= CHANNELS means Cfg_we has no effect.
- Clr=1 with Slt valid: count[Slt] <= 0 and pre[Slt] <= 0. Clr beats En on the same cycle; no increment and no Wrap.
- Divisor write, Cfg_we=1:
  - div[Cfg_sel] <= Cfg_div and pre[Cfg_sel] <= 0.
  - If the same channel also counts this cycle, the step is evaluated with the old div and old pre. The count may increment, but pre is 0 afterwards regardless.
  - The new divisor applies from the next cycle.
  - If Clr and Cfg_we hit the same channel, both take effect.
- Wrap:
  - Wrap[c] is 1 for exactly the one cycle after the edge on which count[c] went from all-ones to 0 via a count step. It is 0 otherwise.
  - Clr never sets Wrap.
- Latency: Count and Wrap are registered. The effect of the inputs at edge N is visible after edge N. There is no combinational path from inputs to outputs.
- Width rule: counts wrap modulo 2^WIDTH; the prescaler never exceeds deff-1.

Test Plan:
- Reset: Reset_n=0 for 2 cycles with En=1, Slt=0 → all Count = 0, Wrap = 0. Release, then 4 enables on ch0 → Count[0] = 1.
- Default prescale: Slt=1, En=1 for 12 cycles → Count[1] = 3, incrementing after the 4th, 8th and 12th edges. Other channels stay 0. Insert 2 En=0 cycles after the 2nd enable → still 3 after 12 enabled cycles.
- Programmed divisors:
  - Cfg_div=0 on ch0, then 10 enables → Count[0] = 10.
  - Cfg_div=3 on ch2, then 9 enables → Count[2] = 3.
  - Write Cfg_div=2 on ch1 while ch1 counts with pre=3 → that cycle increments Count[1]; the next increment comes after 2 further enables.
- Wrap (WIDTH=4, DEFAULT_DIV=1): 15 enables on ch0 → Count[0] = 15, Wrap = 0. 16th enable → Count[0] = 0, and Wrap[0] = 1 for one cycle only.
- Clear/simultaneous events: Count[1]=5, pre=2. Clr=1 with En=1 on Slt=1 → Count[1] = 0, no Wrap. Then 4 enables → Count[1] = 1.
- Range and reset mid-operation:
  - CHANNELS=3, Slt=3, En=1, Clr=1 → no channel changes.
  - With ch1 pre=2, assert Reset_n=0 for 1 cycle → all state 0. Then 4 enables → Count[1] = 1.

Source files
------------

// File: rtl/prescaled_multi_counter_if.sv
// Control/status bundle for prescaled_multi_counter.
// Master drives select, enable and config; slave returns counts and wraps.
interface prescaled_multi_counter_if #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      En;
  logic [SEL_W-1:0]          Slt;
  logic                      Clr;
  logic                      Cfg_we;
  logic [SEL_W-1:0]          Cfg_sel;
  logic [DIV_W-1:0]          Cfg_div;
  logic [CHANNELS*WIDTH-1:0] Count;
  logic [CHANNELS-1:0]       Wrap;

  modport master (
    output En, Slt, Clr, Cfg_we, Cfg_sel, Cfg_div,
    input  Count, Wrap
  );

  modport slave (
    input  En, Slt, Clr, Cfg_we, Cfg_sel, Cfg_div,
    output Count, Wrap
  );
endinterface

// File: rtl/prescaled_multi_counter.sv
// Bank of independent event counters, each behind its own
// programmable prescaler, with per-channel wrap pulses.
module prescaled_multi_counter #(
  parameter int WIDTH       = 64,
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input logic                    Clk,
  input logic                    Reset_n,
  prescaled_multi_counter_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [DIV_W-1:0] r_pre;
    logic [DIV_W-1:0] r_div;
    logic             r_wrap;

    logic             w_sel;
    logic             w_cfg;
    logic             w_clr;
    logic             w_step;
    logic [DIV_W-1:0] w_deff;
    logic             w_roll;

    // Out-of-range selects never match any channel index.
    assign w_sel  = (bus.Slt == SEL_W'(c));
    assign w_cfg  = bus.Cfg_we && (bus.Cfg_sel == SEL_W'(c));
    assign w_clr  = w_sel && bus.Clr;
    assign w_step = w_sel && bus.En && !bus.Clr;
    assign w_deff = (r_div == '0) ? DIV_W'(1) : r_div;
    assign w_roll = (r_pre == w_deff - DIV_W'(1));

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_cnt  <= '0;
        r_pre  <= '0;
        r_div  <= DIV_W'(DEFAULT_DIV);
        r_wrap <= 1'b0;
      end else begin
        r_wrap <= 1'b0;
        if (w_clr) begin
          r_cnt <= '0;
          r_pre <= '0;
        end else if (w_step) begin
          if (w_roll) begin
            r_pre  <= '0;
            r_cnt  <= r_cnt + WIDTH'(1);
            r_wrap <= &r_cnt;
          end else begin
            r_pre <= r_pre + DIV_W'(1);
          end
        end
        // A divisor write restarts the prescale after any step above.
        if (w_cfg) begin
          r_div <= bus.Cfg_div;
          r_pre <= '0;
        end
      end
    end

    assign bus.Count[c*WIDTH +: WIDTH] = r_cnt;
    assign bus.Wrap[c]                 = r_wrap;
  end
endmodule

// File: tb/tb_prescaled_multi_counter.sv
// Directed scoreboard bench: three configurations of the counter bank,
// expectations queued by stimulus and checked by a negedge monitor.
module tb_prescaled_multi_counter;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  prescaled_multi_counter_if #(.WIDTH(64), .CHANNELS(4), .DIV_W(8)) a_if ();
  prescaled_multi_counter_if #(.WIDTH(4), .CHANNELS(4), .DIV_W(8)) w_if ();
  prescaled_multi_counter_if #(.WIDTH(64), .CHANNELS(3), .DIV_W(8)) c_if ();

  prescaled_multi_counter #(
    .WIDTH(64), .CHANNELS(4), .DIV_W(8), .DEFAULT_DIV(4)
  ) u_a (.Clk(Clk), .Reset_n(Reset_n), .bus(a_if));

  prescaled_multi_counter #(
    .WIDTH(4), .CHANNELS(4), .DIV_W(8), .DEFAULT_DIV(1)
  ) u_w (.Clk(Clk), .Reset_n(Reset_n), .bus(w_if));

  prescaled_multi_counter #(
    .WIDTH(64), .CHANNELS(3), .DIV_W(8), .DEFAULT_DIV(4)
  ) u_c (.Clk(Clk), .Reset_n(Reset_n), .bus(c_if));

  typedef struct {
    int          d;
    int          ch;
    logic [63:0] cnt;
    logic [3:0]  wrap;
    string       nm;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [63:0] act_cnt(int d, int ch);
    case (d)
      0: return a_if.Count[ch*64 +: 64];
      1: return {60'b0, w_if.Count[ch*4 +: 4]};
      default: return c_if.Count[ch*64 +: 64];
    endcase
  endfunction

  function automatic logic [3:0] act_wrap(int d);
    case (d)
      0: return a_if.Wrap;
      1: return w_if.Wrap;
      default: return {1'b0, c_if.Wrap};
    endcase
  endfunction

  // Monitor: pops every expectation due by this cycle.
  always @(negedge Clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (act_cnt(e.d, e.ch) !== e.cnt || act_wrap(e.d) !== e.wrap) begin
        n_fail++;
        $display("FAIL %s: count=%0d wrap=%b, required count=%0d wrap=%b",
                 e.nm, act_cnt(e.d, e.ch), act_wrap(e.d), e.cnt, e.wrap);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_exp(int d, int ch, logic [63:0] cnt,
                          logic [3:0] wrap, string nm);
    exp_t e;
    e.d = d; e.ch = ch; e.cnt = cnt; e.wrap = wrap;
    e.nm = nm; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic a_drv(logic en, logic [1:0] slt, logic clr,
                       logic we, logic [1:0] sel, logic [7:0] dv);
    a_if.En = en; a_if.Slt = slt; a_if.Clr = clr;
    a_if.Cfg_we = we; a_if.Cfg_sel = sel; a_if.Cfg_div = dv;
  endtask

  task automatic w_drv(logic en, logic [1:0] slt, logic clr,
                       logic we, logic [1:0] sel, logic [7:0] dv);
    w_if.En = en; w_if.Slt = slt; w_if.Clr = clr;
    w_if.Cfg_we = we; w_if.Cfg_sel = sel; w_if.Cfg_div = dv;
  endtask

  task automatic c_drv(logic en, logic [1:0] slt, logic clr,
                       logic we, logic [1:0] sel, logic [7:0] dv);
    c_if.En = en; c_if.Slt = slt; c_if.Clr = clr;
    c_if.Cfg_we = we; c_if.Cfg_sel = sel; c_if.Cfg_div = dv;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
  endtask

  initial begin
    a_drv(0, 0, 0, 0, 0, 0);
    w_drv(0, 0, 0, 0, 0, 0);
    c_drv(0, 0, 0, 0, 0, 0);

    // Reset held with En high, then first prescaled step
    Reset_n = 1'b0;
    a_drv(1, 0, 0, 0, 0, 0);
    tick(2);
    push_exp(0, 0, 0, 4'b0, "rst_a_c0");
    push_exp(0, 1, 0, 4'b0, "rst_a_c1");
    push_exp(0, 3, 0, 4'b0, "rst_a_c3");
    push_exp(1, 0, 0, 4'b0, "rst_w_c0");
    push_exp(2, 2, 0, 4'b0, "rst_c_c2");
    Reset_n = 1'b1;
    tick(3);
    push_exp(0, 0, 0, 4'b0, "rel_en3");
    tick();
    push_exp(0, 0, 1, 4'b0, "rel_en4");

    // Default prescale with an En gap
    a_drv(0, 0, 0, 0, 0, 0);
    do_reset();
    a_drv(1, 1, 0, 0, 0, 0);
    tick(2);
    a_drv(0, 1, 0, 0, 0, 0);
    tick(2);
    push_exp(0, 1, 0, 4'b0, "gap_hold");
    a_drv(1, 1, 0, 0, 0, 0);
    tick(2);
    push_exp(0, 1, 1, 4'b0, "def_en4");
    tick(4);
    push_exp(0, 1, 2, 4'b0, "def_en8");
    tick(3);
    push_exp(0, 1, 2, 4'b0, "def_en11");
    tick();
    push_exp(0, 1, 3, 4'b0, "def_en12");
    push_exp(0, 0, 0, 4'b0, "def_c0_idle");
    push_exp(0, 2, 0, 4'b0, "def_c2_idle");

    // Divisor 0 behaves as 1, divisor 3
    a_drv(0, 0, 0, 0, 0, 0);
    do_reset();
    a_drv(0, 0, 0, 1, 0, 0);
    tick();
    a_drv(1, 0, 0, 0, 0, 0);
    tick();
    push_exp(0, 0, 1, 4'b0, "div0_en1");
    tick(9);
    push_exp(0, 0, 10, 4'b0, "div0_en10");
    a_drv(0, 0, 0, 1, 2, 3);
    tick();
    a_drv(1, 2, 0, 0, 0, 0);
    tick(8);
    push_exp(0, 2, 2, 4'b0, "div3_en8");
    tick();
    push_exp(0, 2, 3, 4'b0, "div3_en9");

    // Divisor write on the cycle the channel rolls over
    a_drv(0, 0, 0, 0, 0, 0);
    do_reset();
    a_drv(1, 1, 0, 0, 0, 0);
    tick(3);
    push_exp(0, 1, 0, 4'b0, "cfg_pre3");
    a_drv(1, 1, 0, 1, 1, 2);
    tick();
    push_exp(0, 1, 1, 4'b0, "cfg_same_step");
    a_drv(1, 1, 0, 0, 0, 0);
    tick();
    push_exp(0, 1, 1, 4'b0, "div2_en1");
    tick();
    push_exp(0, 1, 2, 4'b0, "div2_en2");

    // Wrap pulse on the narrow instance
    a_drv(0, 0, 0, 0, 0, 0);
    do_reset();
    w_drv(1, 0, 0, 0, 0, 0);
    tick(15);
    push_exp(1, 0, 15, 4'b0, "w_full");
    tick();
    push_exp(1, 0, 0, 4'b0001, "w_wrap");
    w_drv(0, 0, 0, 0, 0, 0);
    tick();
    push_exp(1, 0, 0, 4'b0, "w_wrap_gone");

    // Clear beats enable
    do_reset();
    a_drv(1, 1, 0, 0, 0, 0);
    tick(22);
    push_exp(0, 1, 5, 4'b0, "clr_pre5");
    a_drv(1, 1, 1, 0, 0, 0);
    tick();
    push_exp(0, 1, 0, 4'b0, "clr_beats_en");
    a_drv(1, 1, 0, 0, 0, 0);
    tick(3);
    push_exp(0, 1, 0, 4'b0, "clr_en3");
    tick();
    push_exp(0, 1, 1, 4'b0, "clr_en4");

    // Out-of-range selects on the 3-channel instance
    a_drv(0, 0, 0, 0, 0, 0);
    do_reset();
    c_drv(1, 2, 0, 0, 0, 0);
    tick(5);
    push_exp(2, 2, 1, 4'b0, "rng_c2_pre");
    c_drv(1, 0, 0, 0, 0, 0);
    tick(4);
    push_exp(2, 0, 1, 4'b0, "rng_c0_pre");
    c_drv(1, 3, 1, 1, 3, 1);
    tick(2);
    push_exp(2, 0, 1, 4'b0, "rng_c0_hold");
    push_exp(2, 1, 0, 4'b0, "rng_c1_hold");
    push_exp(2, 2, 1, 4'b0, "rng_c2_hold");
    c_drv(1, 2, 0, 0, 0, 0);
    tick(2);
    push_exp(2, 2, 1, 4'b0, "rng_pre_kept");
    tick();
    push_exp(2, 2, 2, 4'b0, "rng_c2_step");

    // Reset in the middle of a prescale
    c_drv(1, 1, 0, 0, 0, 0);
    tick(2);
    push_exp(2, 1, 0, 4'b0, "mid_pre2");
    Reset_n = 1'b0;
    tick();
    push_exp(2, 0, 0, 4'b0, "mid_rst_c0");
    push_exp(2, 1, 0, 4'b0, "mid_rst_c1");
    push_exp(2, 2, 0, 4'b0, "mid_rst_c2");
    Reset_n = 1'b1;
    tick(3);
    push_exp(2, 1, 0, 4'b0, "mid_en3");
    tick();
    push_exp(2, 1, 1, 4'b0, "mid_en4");

    c_drv(0, 0, 0, 0, 0, 0);
    tick(3);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
